// File: rtl/main_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : main_cpu
//  Description : Single-cycle 8-bit CPU core. Four 8-bit registers (R0..R3),
//                grouped little-endian into pairs P0={R1,R0} and P1={R3,R2},
//                plus a small internal byte-addressed data memory. One 20-bit
//                instruction is sampled and retired on every rising clock
//                edge. Zero and sign status of R0 are exported.
//  Revision    : 1.0 - initial release
// ============================================================================
module main_cpu #(
  parameter int MEM_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] inp,
  output logic        zero_a,
  output logic        sign_a
);

  // Address width of the data memory; addresses wrap modulo MEM_DEPTH.
  localparam int c_addr_w = $clog2(MEM_DEPTH);

  // Opcode encodings
  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_ldi  = 4'h1;
  localparam logic [3:0] c_op_mov  = 4'h2;
  localparam logic [3:0] c_op_add  = 4'h3;
  localparam logic [3:0] c_op_sub  = 4'h4;
  localparam logic [3:0] c_op_and  = 4'h5;
  localparam logic [3:0] c_op_or   = 4'h6;
  localparam logic [3:0] c_op_xor  = 4'h7;
  localparam logic [3:0] c_op_not  = 4'h8;
  localparam logic [3:0] c_op_shl  = 4'h9;
  localparam logic [3:0] c_op_shr  = 4'hA;
  localparam logic [3:0] c_op_ld   = 4'hB;
  localparam logic [3:0] c_op_st   = 4'hC;
  localparam logic [3:0] c_op_ldw  = 4'hD;
  localparam logic [3:0] c_op_stw  = 4'hE;
  localparam logic [3:0] c_op_addw = 4'hF;

  // Architectural state
  logic [3:0][7:0]           reg_q, reg_d;
  logic [MEM_DEPTH-1:0][7:0] mem_q, mem_d;

  // Decoded instruction fields
  logic [3:0]          w_op;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs;
  logic [c_addr_w-1:0] w_addr_lo;
  logic [c_addr_w-1:0] w_addr_hi;
  logic [7:0]          w_imm;

  // Operand values (pre-edge, so rd == rs reads the old value)
  logic [7:0]  w_rd_val;
  logic [7:0]  w_rs_val;

  // Register-pair views: k selects by rd[1], j selects by rs[1]
  logic [1:0]  w_pk_lo_idx;
  logic [1:0]  w_pk_hi_idx;
  logic [1:0]  w_pj_lo_idx;
  logic [1:0]  w_pj_hi_idx;
  logic [15:0] w_pk_val;
  logic [15:0] w_pj_val;
  logic [15:0] w_word_sum;

  assign w_op      = inp[19:16];
  assign w_rd      = inp[15:14];
  assign w_rs      = inp[13:12];
  assign w_addr_lo = inp[8 +: c_addr_w];
  assign w_addr_hi = w_addr_lo + c_addr_w'(1);
  assign w_imm     = inp[7:0];

  assign w_rd_val  = reg_q[w_rd];
  assign w_rs_val  = reg_q[w_rs];

  // Even register holds the low byte of its pair.
  assign w_pk_lo_idx = {w_rd[1], 1'b0};
  assign w_pk_hi_idx = {w_rd[1], 1'b1};
  assign w_pj_lo_idx = {w_rs[1], 1'b0};
  assign w_pj_hi_idx = {w_rs[1], 1'b1};
  assign w_pk_val    = {reg_q[w_pk_hi_idx], reg_q[w_pk_lo_idx]};
  assign w_pj_val    = {reg_q[w_pj_hi_idx], reg_q[w_pj_lo_idx]};
  assign w_word_sum  = w_pk_val + w_pj_val;

  // Next-state logic: decode the opcode and compute register/memory updates.
  always_comb begin
    reg_d = reg_q;
    mem_d = mem_q;
    unique case (w_op)
      c_op_nop:  ;
      c_op_ldi:  reg_d[w_rd] = w_imm;
      c_op_mov:  reg_d[w_rd] = w_rs_val;
      c_op_add:  reg_d[w_rd] = w_rd_val + w_rs_val;
      c_op_sub:  reg_d[w_rd] = w_rd_val - w_rs_val;
      c_op_and:  reg_d[w_rd] = w_rd_val & w_rs_val;
      c_op_or:   reg_d[w_rd] = w_rd_val | w_rs_val;
      c_op_xor:  reg_d[w_rd] = w_rd_val ^ w_rs_val;
      c_op_not:  reg_d[w_rd] = ~w_rs_val;
      c_op_shl:  reg_d[w_rd] = {w_rd_val[6:0], 1'b0};
      c_op_shr:  reg_d[w_rd] = {1'b0, w_rd_val[7:1]};
      c_op_ld:   reg_d[w_rd] = mem_q[w_addr_lo];
      c_op_st:   mem_d[w_addr_lo] = w_rs_val;
      c_op_ldw: begin
        reg_d[w_pk_lo_idx] = mem_q[w_addr_lo];
        reg_d[w_pk_hi_idx] = mem_q[w_addr_hi];
      end
      c_op_stw: begin
        // High byte address wraps, so a word at the top lands at address 0.
        mem_d[w_addr_lo] = reg_q[w_pj_lo_idx];
        mem_d[w_addr_hi] = reg_q[w_pj_hi_idx];
      end
      c_op_addw: begin
        reg_d[w_pk_lo_idx] = w_word_sum[7:0];
        reg_d[w_pk_hi_idx] = w_word_sum[15:8];
      end
      default: ;
    endcase
  end

  // State registers: reset clears everything and discards the instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_q <= '0;
      mem_q <= '0;
    end else begin
      reg_q <= reg_d;
      mem_q <= mem_d;
    end
  end

  // Status outputs depend only on the accumulator R0.
  assign zero_a = (reg_q[0] == 8'h00);
  assign sign_a = reg_q[0][7];

endmodule
`default_nettype wire

// File: tb/tb_main_cpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_main_cpu
//  Description : Self-checking bench for main_cpu. Each issued instruction
//                pushes the expected accumulator state onto a queue; the
//                observed state after the edge is queued alongside, and each
//                scenario task drains and compares both queues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_main_cpu;

    typedef struct packed {
        logic [7:0] r0;
        logic       z;
        logic       s;
    } obs_t;

    logic        clk;
    logic        rst;
    logic [19:0] inp;
    logic        zero_a;
    logic        sign_a;

    int errors;
    int checks;

    obs_t exp_q[$];
    obs_t obs_q[$];

    main_cpu #(.MEM_DEPTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .inp    (inp),
        .zero_a (zero_a),
        .sign_a (sign_a)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [3:0] addr,
                                        input logic [7:0] imm);
        return {op, rd, rs, addr, imm};
    endfunction

    // Expected status is derived from the expected accumulator value.
    function automatic obs_t mk_exp(input logic [7:0] r0);
        obs_t e;
        e.r0 = r0;
        e.z  = (r0 == 8'h00);
        e.s  = r0[7];
        return e;
    endfunction

    // Drive one instruction, record its expectation, then capture the result.
    task automatic issue(input logic r, input logic [19:0] instr, input logic [7:0] exp_r0);
        obs_t o;
        @(negedge clk);
        rst = r;
        inp = instr;
        exp_q.push_back(mk_exp(exp_r0));
        @(posedge clk);
        #1;
        o.r0 = dut.reg_q[0];
        o.z  = zero_a;
        o.s  = sign_a;
        obs_q.push_back(o);
        rst = 1'b0;
        inp = 20'h0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        issue(1'b1, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h80), 8'h00);
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h80), 8'h80);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL reset: no observation, required r0=%h", e.r0);
            end else begin
                o = obs_q.pop_front();
                checks++; if (o.r0 !== e.r0) begin errors++; $display("FAIL reset r0: got %h want %h", o.r0, e.r0); end
                checks++; if (o.z  !== e.z)  begin errors++; $display("FAIL reset zero_a: got %b want %b", o.z, e.z); end
                checks++; if (o.s  !== e.s)  begin errors++; $display("FAIL reset sign_a: got %b want %b", o.s, e.s); end
            end
        end
    endtask

    task automatic test_arith();
        obs_t e, o;
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'hFF), 8'hFF); // LDI R0,FF
        issue(1'b0, ins(4'h1, 2'd1, 2'd0, 4'h0, 8'h01), 8'hFF); // LDI R1,01
        issue(1'b0, ins(4'h3, 2'd0, 2'd1, 4'h0, 8'h00), 8'h00); // ADD R0,R1 wraps
        issue(1'b0, ins(4'h4, 2'd0, 2'd1, 4'h0, 8'h00), 8'hFF); // SUB R0,R1 borrows
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h41), 8'h41); // LDI R0,41
        issue(1'b0, ins(4'h3, 2'd0, 2'd0, 4'h0, 8'h00), 8'h82); // ADD R0,R0 doubles
        issue(1'b0, ins(4'h1, 2'd2, 2'd0, 4'h0, 8'h0F), 8'h82); // LDI R2,0F
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h3C), 8'h3C); // LDI R0,3C
        issue(1'b0, ins(4'h5, 2'd0, 2'd2, 4'h0, 8'h00), 8'h0C); // AND R0,R2
        issue(1'b0, ins(4'h6, 2'd0, 2'd2, 4'h0, 8'h00), 8'h0F); // OR  R0,R2
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL arith: no observation, required r0=%h", e.r0);
            end else begin
                o = obs_q.pop_front();
                checks++; if (o.r0 !== e.r0) begin errors++; $display("FAIL arith r0: got %h want %h", o.r0, e.r0); end
                checks++; if (o.z  !== e.z)  begin errors++; $display("FAIL arith zero_a: got %b want %b", o.z, e.z); end
                checks++; if (o.s  !== e.s)  begin errors++; $display("FAIL arith sign_a: got %b want %b", o.s, e.s); end
            end
        end
    endtask

    task automatic test_logic_shift();
        obs_t e, o;
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'hA5), 8'hA5); // LDI R0,A5
        issue(1'b0, ins(4'h8, 2'd0, 2'd0, 4'h0, 8'h00), 8'h5A); // NOT R0,R0
        issue(1'b0, ins(4'h9, 2'd0, 2'd0, 4'h0, 8'h00), 8'hB4); // SHL R0
        issue(1'b0, ins(4'hA, 2'd0, 2'd0, 4'h0, 8'h00), 8'h5A); // SHR R0
        issue(1'b0, ins(4'h7, 2'd0, 2'd0, 4'h0, 8'h00), 8'h00); // XOR R0,R0
        issue(1'b0, ins(4'h1, 2'd3, 2'd0, 4'h0, 8'h99), 8'h00); // LDI R3,99
        issue(1'b0, ins(4'h2, 2'd0, 2'd3, 4'h0, 8'h00), 8'h99); // MOV R0,R3
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL logic: no observation, required r0=%h", e.r0);
            end else begin
                o = obs_q.pop_front();
                checks++; if (o.r0 !== e.r0) begin errors++; $display("FAIL logic r0: got %h want %h", o.r0, e.r0); end
                checks++; if (o.z  !== e.z)  begin errors++; $display("FAIL logic zero_a: got %b want %b", o.z, e.z); end
                checks++; if (o.s  !== e.s)  begin errors++; $display("FAIL logic sign_a: got %b want %b", o.s, e.s); end
            end
        end
    endtask

    task automatic test_word_mem();
        obs_t e, o;
        issue(1'b0, ins(4'h1, 2'd2, 2'd0, 4'h0, 8'h34), 8'h99); // LDI R2,34
        issue(1'b0, ins(4'h1, 2'd3, 2'd0, 4'h0, 8'h12), 8'h99); // LDI R3,12
        issue(1'b0, ins(4'hE, 2'd0, 2'd2, 4'hF, 8'h00), 8'h99); // STW [15],P1
        issue(1'b0, ins(4'hB, 2'd0, 2'd0, 4'hF, 8'h00), 8'h34); // LD R0,[15]
        issue(1'b0, ins(4'hB, 2'd0, 2'd0, 4'h0, 8'h00), 8'h12); // LD R0,[0] wrap
        issue(1'b0, ins(4'h1, 2'd1, 2'd0, 4'h0, 8'h00), 8'h12); // LDI R1,00
        issue(1'b0, ins(4'hD, 2'd0, 2'd0, 4'hF, 8'h00), 8'h34); // LDW P0,[15]
        issue(1'b0, ins(4'h2, 2'd0, 2'd1, 4'h0, 8'h00), 8'h12); // MOV R0,R1
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h5C), 8'h5C); // LDI R0,5C
        issue(1'b0, ins(4'hC, 2'd0, 2'd0, 4'h7, 8'h00), 8'h5C); // ST [7],R0
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h00), 8'h00); // LDI R0,00
        issue(1'b0, ins(4'hB, 2'd0, 2'd0, 4'h7, 8'h00), 8'h5C); // LD R0,[7]
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL word: no observation, required r0=%h", e.r0);
            end else begin
                o = obs_q.pop_front();
                checks++; if (o.r0 !== e.r0) begin errors++; $display("FAIL word r0: got %h want %h", o.r0, e.r0); end
                checks++; if (o.z  !== e.z)  begin errors++; $display("FAIL word zero_a: got %b want %b", o.z, e.z); end
                checks++; if (o.s  !== e.s)  begin errors++; $display("FAIL word sign_a: got %b want %b", o.s, e.s); end
            end
        end
    endtask

    task automatic test_addw();
        obs_t e, o;
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'hFF), 8'hFF); // LDI R0,FF
        issue(1'b0, ins(4'h1, 2'd1, 2'd0, 4'h0, 8'h00), 8'hFF); // LDI R1,00
        issue(1'b0, ins(4'h1, 2'd2, 2'd0, 4'h0, 8'h01), 8'hFF); // LDI R2,01
        issue(1'b0, ins(4'h1, 2'd3, 2'd0, 4'h0, 8'h00), 8'hFF); // LDI R3,00
        issue(1'b0, ins(4'hF, 2'd0, 2'd2, 4'h0, 8'h00), 8'h00); // ADDW P0,P1
        issue(1'b0, ins(4'h2, 2'd0, 2'd1, 4'h0, 8'h00), 8'h01); // MOV R0,R1 (carry)
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL addw: no observation, required r0=%h", e.r0);
            end else begin
                o = obs_q.pop_front();
                checks++; if (o.r0 !== e.r0) begin errors++; $display("FAIL addw r0: got %h want %h", o.r0, e.r0); end
                checks++; if (o.z  !== e.z)  begin errors++; $display("FAIL addw zero_a: got %b want %b", o.z, e.z); end
                checks++; if (o.s  !== e.s)  begin errors++; $display("FAIL addw sign_a: got %b want %b", o.s, e.s); end
            end
        end
    endtask

    task automatic test_nop_reset();
        obs_t e, o;
        issue(1'b0, ins(4'h1, 2'd0, 2'd0, 4'h0, 8'h7F), 8'h7F); // LDI R0,7F
        issue(1'b0, 20'h00000,                           8'h7F); // NOP
        issue(1'b1, ins(4'hC, 2'd0, 2'd0, 4'h3, 8'h00), 8'h00); // rst with ST pending
        issue(1'b0, ins(4'hB, 2'd0, 2'd0, 4'h3, 8'h00), 8'h00); // LD R0,[3]
        issue(1'b0, ins(4'hB, 2'd0, 2'd0, 4'h7, 8'h00), 8'h00); // LD R0,[7] cleared
        issue(1'b0, ins(4'h2, 2'd0, 2'd3, 4'h0, 8'h00), 8'h00); // MOV R0,R3 cleared
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() == 0) begin
                errors++; checks++;
                $display("FAIL nop_reset: no observation, required r0=%h", e.r0);
            end else begin
                o = obs_q.pop_front();
                checks++; if (o.r0 !== e.r0) begin errors++; $display("FAIL nop_reset r0: got %h want %h", o.r0, e.r0); end
                checks++; if (o.z  !== e.z)  begin errors++; $display("FAIL nop_reset zero_a: got %b want %b", o.z, e.z); end
                checks++; if (o.s  !== e.s)  begin errors++; $display("FAIL nop_reset sign_a: got %b want %b", o.s, e.s); end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b0;
        inp    = 20'h0;
        test_reset();
        test_arith();
        test_logic_shift();
        test_word_mem();
        test_addw();
        test_nop_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
